round_timer_ctrl: RTL and testbench

Sequencing controller for a two-digit BCD game-round countdown built from two cascaded 4-bit loadable down-counter digits (tens, units). It generates the per-digit load, data and count-enable controls, and divides CP into a one-second tick. It monitors the digit outputs to handle the units-to-tens borrow and round expiry. It sits between the game FSM (start/pause/timeout) and the counter digits that feed the score/time display.

---
 rtl/round_timer_ctrl_if.sv | 45 ++++
 rtl/round_timer_ctrl.sv | 173 +++++++++++++++++
 tb/tb_round_timer_ctrl.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/round_timer_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : round_timer_ctrl_if                                          |
// | Description : Control/status bus between the round timer sequencer and     |
// |               the two cascaded BCD down-counter digits (tens, units).      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface round_timer_ctrl_if;
    logic [3:0] q_tens;
    logic [3:0] q_units;
    logic       ld_tens_n;
    logic       ld_units_n;
    logic [3:0] d_tens;
    logic [3:0] d_units;
    logic       ctp;
    logic       ctt_units;
    logic       ctt_tens;

    // Sequencer side: watches the digits, drives load/enable controls.
    modport master (
        input  q_tens,
        input  q_units,
        output ld_tens_n,
        output ld_units_n,
        output d_tens,
        output d_units,
        output ctp,
        output ctt_units,
        output ctt_tens
    );

    // Counter-digit side.
    modport slave (
        output q_tens,
        output q_units,
        input  ld_tens_n,
        input  ld_units_n,
        input  d_tens,
        input  d_units,
        input  ctp,
        input  ctt_units,
        input  ctt_tens
    );
endinterface
`default_nettype wire

// File: rtl/round_timer_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : round_timer_ctrl                                             |
// | Description : Two-digit BCD round countdown sequencer: one-second          |
// |               prescaler, digit load/borrow control, pause and expiry.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module round_timer_ctrl #(
    parameter int TICK_DIV = 50000000,
    parameter int TICK_W   = 26
) (
    input  wire                 CP,
    input  wire                 CR,
    input  wire                 start,
    input  wire                 pause,
    input  wire  [3:0]          preset_tens,
    input  wire  [3:0]          preset_units,
    round_timer_ctrl_if.master  dig,
    output logic                running,
    output logic                paused,
    output logic                timeout
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [3:0]        DIGIT_MAX = 4'd9;

    state_t              state_q, state_d;
    logic [TICK_W-1:0]   presc_q, presc_d;
    logic                start_q;

    logic                ld_tens_n_q,  ld_tens_n_d;
    logic                ld_units_n_q, ld_units_n_d;
    logic [3:0]          d_tens_q,     d_tens_d;
    logic [3:0]          d_units_q,    d_units_d;
    logic                ctp_q,        ctp_d;
    logic                ctt_units_q,  ctt_units_d;
    logic                ctt_tens_q,   ctt_tens_d;
    logic                running_q,    running_d;
    logic                paused_q,     paused_d;
    logic                timeout_q,    timeout_d;

    logic                start_rise;
    logic                tick_now;
    logic                tick_next;
    logic                q_zero;
    logic                q_last;

    function automatic logic [3:0] clamp_bcd(input logic [3:0] v);
        return (v > DIGIT_MAX) ? DIGIT_MAX : v;
    endfunction

    assign start_rise = start & ~start_q;
    assign tick_now   = (state_q == ST_RUN) && (presc_q == TICK_LAST);
    assign q_zero     = (dig.q_tens == 4'd0) && (dig.q_units == 4'd0);
    assign q_last     = (dig.q_tens == 4'd0) && (dig.q_units == 4'd1);

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        case (state_q)
            ST_IDLE: begin
                if (start_rise) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                presc_d = '0;
                state_d = ((d_tens_q == 4'd0) && (d_units_q == 4'd0)) ? ST_DONE : ST_RUN;
            end
            ST_RUN: begin
                presc_d = tick_now ? '0 : presc_q + TICK_W'(1);
                if (start_rise)                        state_d = ST_LOAD;
                else if (q_zero || (tick_now && q_last)) state_d = ST_DONE;
                else if (pause)                        state_d = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (start_rise)  state_d = ST_LOAD;
                else if (!pause) state_d = ST_RUN;
            end
            ST_DONE: begin
                if (start_rise) state_d = ST_LOAD;
            end
            default: state_d = ST_IDLE;
        endcase
        if ((state_d != ST_RUN) && (state_d != ST_PAUSE)) presc_d = '0;
    end

    // Outputs are registered, so they are decided one cycle ahead from the
    // next state. The digits cannot change on the cycle before a tick as long
    // as TICK_DIV >= 2, so the current q values are valid for that decision.
    assign tick_next = (state_d == ST_RUN) && (presc_d == TICK_LAST);

    always_comb begin
        ld_tens_n_d  = 1'b1;
        ld_units_n_d = 1'b1;
        d_tens_d     = 4'd0;
        d_units_d    = 4'd0;
        ctp_d        = 1'b0;
        ctt_units_d  = 1'b0;
        ctt_tens_d   = 1'b0;
        running_d    = (state_d == ST_RUN);
        paused_d     = (state_d == ST_PAUSE);
        timeout_d    = (state_d == ST_DONE) && (state_q != ST_DONE);
        if (state_d == ST_LOAD) begin
            ld_tens_n_d  = 1'b0;
            ld_units_n_d = 1'b0;
            d_tens_d     = clamp_bcd(preset_tens);
            d_units_d    = clamp_bcd(preset_units);
        end else if (tick_next) begin
            if (dig.q_units != 4'd0) begin
                ctp_d       = 1'b1;
                ctt_units_d = 1'b1;
            end else if (dig.q_tens != 4'd0) begin
                // Borrow: reload units with 9 while the tens digit steps down.
                ld_units_n_d = 1'b0;
                d_units_d    = DIGIT_MAX;
                ctp_d        = 1'b1;
                ctt_tens_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge CP or posedge CR) begin
        if (CR) begin
            state_q      <= ST_IDLE;
            presc_q      <= '0;
            start_q      <= 1'b0;
            ld_tens_n_q  <= 1'b1;
            ld_units_n_q <= 1'b1;
            d_tens_q     <= 4'd0;
            d_units_q    <= 4'd0;
            ctp_q        <= 1'b0;
            ctt_units_q  <= 1'b0;
            ctt_tens_q   <= 1'b0;
            running_q    <= 1'b0;
            paused_q     <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            start_q      <= start;
            ld_tens_n_q  <= ld_tens_n_d;
            ld_units_n_q <= ld_units_n_d;
            d_tens_q     <= d_tens_d;
            d_units_q    <= d_units_d;
            ctp_q        <= ctp_d;
            ctt_units_q  <= ctt_units_d;
            ctt_tens_q   <= ctt_tens_d;
            running_q    <= running_d;
            paused_q     <= paused_d;
            timeout_q    <= timeout_d;
        end
    end

    assign dig.ld_tens_n  = ld_tens_n_q;
    assign dig.ld_units_n = ld_units_n_q;
    assign dig.d_tens     = d_tens_q;
    assign dig.d_units    = d_units_q;
    assign dig.ctp        = ctp_q;
    assign dig.ctt_units  = ctt_units_q;
    assign dig.ctt_tens   = ctt_tens_q;
    assign running        = running_q;
    assign paused         = paused_q;
    assign timeout        = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_round_timer_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_round_timer_ctrl                                          |
// | Description : Bench for round_timer_ctrl with two BCD counter digits and   |
// |               a seconds-level reference model.                             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_round_timer_ctrl;

    localparam int DIV     = 4;
    localparam int M_IDLE  = 0;
    localparam int M_LOAD  = 1;
    localparam int M_RUN   = 2;
    localparam int M_PAUSE = 3;
    localparam int M_DONE  = 4;

    logic       CP = 1'b0;
    logic       CR = 1'b0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic [3:0] preset_tens = 4'd0;
    logic [3:0] preset_units = 4'd0;
    logic       running, paused, timeout;

    round_timer_ctrl_if dig();

    round_timer_ctrl #(.TICK_DIV(DIV), .TICK_W(3)) dut (
        .CP           (CP),
        .CR           (CR),
        .start        (start),
        .pause        (pause),
        .preset_tens  (preset_tens),
        .preset_units (preset_units),
        .dig          (dig),
        .running      (running),
        .paused       (paused),
        .timeout      (timeout)
    );

    always #5 CP = ~CP;

    // Two loadable BCD down-counter digits; load beats count, not reset here.
    logic [3:0] pt = 4'd0;
    logic [3:0] pu = 4'd0;
    assign dig.q_tens  = pt;
    assign dig.q_units = pu;
    always @(posedge CP) begin
        if (!dig.ld_units_n)                pu <= dig.d_units;
        else if (dig.ctp && dig.ctt_units)  pu <= pu - 4'd1;
        if (!dig.ld_tens_n)                 pt <= dig.d_tens;
        else if (dig.ctp && dig.ctt_tens)   pt <= pt - 4'd1;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int act, input int req);
        checks = checks + 1;
        if (act !== req) begin
            errors = errors + 1;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Reference model: seconds remaining, cycles into the current second, mode.
    int         m_mode  = M_IDLE;
    int         m_secs  = 0;
    int         m_phase = 0;
    bit         m_sprev = 1'b0;
    bit         m_to    = 1'b0;
    logic [3:0] m_dt    = 4'd0;
    logic [3:0] m_du    = 4'd0;
    int         m_prev;
    bit         m_rise, m_tick;

    always @(posedge CP or posedge CR) begin
        if (CR) begin
            m_mode  = M_IDLE;
            m_phase = 0;
            m_sprev = 1'b0;
            m_to    = 1'b0;
        end else begin
            m_prev  = m_mode;
            m_rise  = start && !m_sprev;
            m_sprev = start;
            m_tick  = (m_mode == M_RUN) && (m_phase == DIV - 1);
            case (m_mode)
                M_IDLE:  if (m_rise) m_mode = M_LOAD;
                M_LOAD: begin
                    m_secs  = 10 * int'(m_dt) + int'(m_du);
                    m_phase = 0;
                    m_mode  = (m_secs == 0) ? M_DONE : M_RUN;
                end
                M_RUN: begin
                    if (m_tick && m_secs > 0) m_secs = m_secs - 1;
                    m_phase = m_tick ? 0 : m_phase + 1;
                    if (m_rise)           m_mode = M_LOAD;
                    else if (m_secs == 0) m_mode = M_DONE;
                    else if (pause)       m_mode = M_PAUSE;
                end
                M_PAUSE: begin
                    if (m_rise)      m_mode = M_LOAD;
                    else if (!pause) m_mode = M_RUN;
                end
                default: if (m_rise) m_mode = M_LOAD;
            endcase
            if (m_mode == M_LOAD && m_prev != M_LOAD) begin
                m_dt = (preset_tens  > 4'd9) ? 4'd9 : preset_tens;
                m_du = (preset_units > 4'd9) ? 4'd9 : preset_units;
            end
            m_to = (m_mode == M_DONE) && (m_prev != M_DONE);
        end
    end

    int cyc = 0;
    int n_load = 0, n_to = 0, n_ctp = 0, n_units = 0, n_borrow = 0, n_borrow_ok = 0;
    int load_cyc = 0, run_cyc = 0, to_cyc = 0, ctp_cyc = 0;
    bit run_prev = 1'b0;
    bit e_tick, e_units, e_borrow, e_load;
    logic [15:0] exp_v, act_v;

    always @(posedge CP) begin
        #1;
        cyc      = cyc + 1;
        e_tick   = (m_mode == M_RUN) && (m_phase == DIV - 1);
        e_units  = e_tick && (m_secs % 10 != 0);
        e_borrow = e_tick && (m_secs % 10 == 0) && (m_secs >= 10);
        e_load   = (m_mode == M_LOAD);
        exp_v = {!e_load, !(e_load || e_borrow),
                 e_load ? m_dt : 4'd0,
                 e_load ? m_du : (e_borrow ? 4'd9 : 4'd0),
                 e_units || e_borrow, e_units, e_borrow,
                 m_mode == M_RUN, m_mode == M_PAUSE, m_to};
        act_v = {dig.ld_tens_n, dig.ld_units_n, dig.d_tens, dig.d_units,
                 dig.ctp, dig.ctt_units, dig.ctt_tens, running, paused, timeout};
        chk("cycle_outputs", int'(act_v), int'(exp_v));
        chk("cycle_digits", int'(pt) * 10 + int'(pu), m_secs);
        if (!dig.ld_tens_n) begin n_load = n_load + 1; load_cyc = cyc; end
        if (running && !run_prev) run_cyc = cyc;
        run_prev = running;
        if (timeout) begin n_to = n_to + 1; to_cyc = cyc; end
        if (dig.ctp) begin n_ctp = n_ctp + 1; ctp_cyc = cyc; end
        if (dig.ctt_units) n_units = n_units + 1;
        if (dig.ctt_tens) begin
            n_borrow = n_borrow + 1;
            if (dig.d_units == 4'd9 && !dig.ld_units_n) n_borrow_ok = n_borrow_ok + 1;
        end
    end

    task automatic clr_mon();
        n_load = 0; n_to = 0; n_ctp = 0; n_units = 0; n_borrow = 0; n_borrow_ok = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rel_cyc, n0, wait_n;
        logic [7:0] held;
        #1 CR = 1'b1;
        repeat (2) @(negedge CP);
        chk("reset_ld_n", int'({dig.ld_tens_n, dig.ld_units_n}), 3);
        chk("reset_ctrl", int'({dig.d_tens, dig.d_units, dig.ctp, dig.ctt_units,
                                dig.ctt_tens, running, paused, timeout}), 0);
        CR = 1'b0;
        @(negedge CP);

        // 1: preset 12, full countdown with one borrow
        preset_tens = 4'd1; preset_units = 4'd2; clr_mon();
        start = 1'b1; @(negedge CP); start = 1'b0;
        chk("t1_load", int'({dig.ld_tens_n, dig.ld_units_n, dig.d_tens, dig.d_units}), 'h012);
        for (int i = 0; i < 200 && n_to == 0; i++) @(negedge CP);
        chk("t1_timeout_seen", int'(n_to != 0), 1);
        repeat (3) @(negedge CP);
        chk("t1_to_latency", to_cyc - run_cyc, 48);
        chk("t1_to_count", n_to, 1);
        chk("t1_units_ticks", n_units, 11);
        chk("t1_borrow", n_borrow * 16 + n_borrow_ok, 'h11);
        chk("t1_end", int'({pt, pu, running}), 0);

        // 2: preset 00 expires straight from LOAD
        preset_tens = 4'd0; preset_units = 4'd0; clr_mon();
        start = 1'b1; @(negedge CP); start = 1'b0;
        repeat (3) @(negedge CP);
        chk("t2_to_latency", to_cyc - load_cyc, 1);
        chk("t2_to_count", n_to, 1);
        chk("t2_no_ctp", n_ctp, 0);

        // 3: over-range presets clamp to 99
        preset_tens = 4'd12; preset_units = 4'd15; clr_mon();
        start = 1'b1; @(negedge CP); start = 1'b0;
        chk("t3_load", int'({dig.ld_tens_n, dig.ld_units_n, dig.d_tens, dig.d_units}), 'h099);
        repeat (13) @(negedge CP);
        chk("t3_digits", int'({pt, pu}), 'h96);

        // 4: restart to 08, pause at 07 with prescaler held at 2
        preset_tens = 4'd0; preset_units = 4'd8;
        start = 1'b1; @(negedge CP); start = 1'b0;
        chk("t4_load", int'({dig.ld_tens_n, dig.d_tens, dig.d_units}), 'h008);
        @(negedge CP);
        chk("t4_running", int'(running), 1);
        repeat (5) @(negedge CP);
        pause = 1'b1;
        @(negedge CP);
        chk("t4_paused", int'({paused, running}), 2);
        n0 = n_ctp;
        repeat (19) @(negedge CP);
        chk("t4_hold", int'({pt, pu}) * 256 + (n_ctp - n0), 'h0700);
        pause = 1'b0; rel_cyc = cyc;
        repeat (3) @(negedge CP);
        chk("t4_resume_tick", ctp_cyc - rel_cyc, 2);
        chk("t4_digits", int'({pt, pu}), 'h06);

        // 5: held start restarts once; restart beats pause
        repeat (5) @(negedge CP);
        chk("t5_at_05", int'({pt, pu}), 'h05);
        n0 = n_load;
        start = 1'b1; repeat (10) @(negedge CP); start = 1'b0;
        chk("t5_single_load", n_load - n0, 1);
        @(negedge CP);
        n0 = n_load;
        start = 1'b1; pause = 1'b1; @(negedge CP); start = 1'b0; pause = 1'b0;
        chk("t5_load_wins", int'({dig.ld_tens_n, paused, running}), 0);
        @(negedge CP);
        chk("t5_load_once", n_load - n0, 1);

        // 6: async reset on a tick cycle
        wait_n = 0;
        while (!dig.ctp && wait_n < 40) begin @(negedge CP); wait_n++; end
        chk("t6_tick_found", int'(dig.ctp), 1);
        held = {pt, pu};
        CR = 1'b1;
        #1;
        chk("t6_async_ld_n", int'({dig.ld_tens_n, dig.ld_units_n}), 3);
        chk("t6_async_ctrl", int'({dig.ctp, dig.ctt_units, dig.ctt_tens, running, paused, timeout}), 0);
        @(negedge CP);
        chk("t6_digits_held", int'({pt, pu}), int'(held));
        CR = 1'b0;
        @(negedge CP);
        preset_tens = 4'd2; preset_units = 4'd5;
        start = 1'b1; @(negedge CP); start = 1'b0;
        chk("t6_reload", int'({dig.ld_tens_n, dig.ld_units_n, dig.d_tens, dig.d_units}), 'h025);
        repeat (20) @(negedge CP);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
